// File: rtl/upsample_interp.sv
// Fills the zero-stuffed 2x upsampler stream: averages stuffed columns on even rows, repeats the row above on odd rows.
// Define INTERP_ROUND_EN to round the horizontal average half-up instead of truncating.
module upsample_interp #(
    parameter int WIDTH  = 1600,
    parameter int HEIGHT = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] din,
    output logic       valid_out,
    output logic [7:0] dout,
    output logic       frame_done
);

    localparam int          AW       = $clog2(WIDTH);
    localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);
`ifdef INTERP_ROUND_EN
    localparam logic [8:0]  ROUND    = 9'd1;
`else
    localparam logic [8:0]  ROUND    = 9'd0;
`endif

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [10:0] in_col;
    logic [10:0] in_row;
    logic [10:0] out_col;
    logic [10:0] out_row;
    logic [1:0]  occ;
    logic [1:0]  occ_next;
    logic [7:0]  pipe0;
    logic [7:0]  pipe1;
    logic [7:0]  pipe0_next;
    logic [7:0]  pipe1_next;
    logic [7:0]  last_real;
    logic [7:0]  linebuf [WIDTH];

    logic        push;
    logic        emit;
    logic        in_last;
    logic        out_last;
    logic [8:0]  sum;
    logic [7:0]  avg;
    logic [7:0]  even_val;
    logic [7:0]  out_val;

    assign in_last  = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign out_last = (out_row == ROW_LAST) && (out_col == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN ends on the frame's final output; the next frame's beats may already be queued.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (valid_in && occ == 2'd1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (valid_in && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_last) begin
                    state_next = (occ_next == 2'd2) ? RUN : FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        push = valid_in;
        emit = 1'b0;
        case (state)
            FILL:    emit = 1'b0;
            RUN:     emit = valid_in;
            DRAIN:   emit = 1'b1;
            default: emit = 1'b0;
        endcase
    end

    // Two-entry FIFO of pending beats: pop the oldest on emit, then append the new beat.
    always_comb begin
        pipe0_next = pipe0;
        pipe1_next = pipe1;
        occ_next   = occ;
        if (emit) begin
            pipe0_next = pipe1;
            occ_next   = occ - 2'd1;
        end
        if (push) begin
            if (occ_next == 2'd0) begin
                pipe0_next = din;
            end else begin
                pipe1_next = din;
            end
            occ_next = occ_next + 2'd1;
        end
    end

    // Odd column: left neighbour was the last real pixel emitted, right neighbour is the newest pending beat.
    assign sum = {1'b0, last_real} + {1'b0, pipe1} + ROUND;
    assign avg = sum[8:1];

    always_comb begin
        if (!out_col[0]) begin
            even_val = pipe0;
        end else if (out_col == COL_LAST) begin
            even_val = last_real;
        end else begin
            even_val = avg;
        end
        out_val = out_row[0] ? linebuf[out_col[AW-1:0]] : even_val;
    end

    always_ff @(posedge clk) begin
        if (emit && !out_row[0]) begin
            linebuf[out_col[AW-1:0]] <= even_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_col     <= '0;
            in_row     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            occ        <= '0;
            pipe0      <= '0;
            pipe1      <= '0;
            last_real  <= '0;
            valid_out  <= 1'b0;
            dout       <= '0;
            frame_done <= 1'b0;
        end else begin
            occ   <= occ_next;
            pipe0 <= pipe0_next;
            pipe1 <= pipe1_next;
            if (valid_in) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? 11'd0 : in_row + 11'd1;
                end else begin
                    in_col <= in_col + 11'd1;
                end
            end
            if (emit) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? 11'd0 : out_row + 11'd1;
                end else begin
                    out_col <= out_col + 11'd1;
                end
                if (!out_col[0]) begin
                    last_real <= pipe0;
                end
                dout <= out_val;
            end
            valid_out  <= emit;
            frame_done <= emit && out_last;
        end
    end

endmodule

// File: tb/tb_upsample_interp.sv
// Randomized bench for upsample_interp: a frame-level model predicts every output value and the edge it must appear after.
module tb_upsample_interp;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
`ifdef INTERP_ROUND_EN
    localparam int RND      = 1;
    localparam int RND_COL1 = 16;
`else
    localparam int RND      = 0;
    localparam int RND_COL1 = 15;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] din      = 8'd0;
    logic       valid_out;
    logic [7:0] dout;
    logic       frame_done;

    int checks    = 0;
    int errors    = 0;
    int edge_cnt  = 0;
    int fd_seen   = 0;
    int fd_expect = 0;

    typedef struct {
        int due;
        int val;
        int fd;
    } exp_t;

    exp_t exp_q[$];
    int   frame_in  [H][W];
    int   frame_out [H][W];

    upsample_interp #(
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout      (dout),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, actual, expected);
        end
    endtask

    // Stuffed positions carry junk so the DUT must ignore them.
    task automatic buildFrame(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                frame_in[r][c] = int'($urandom_range(0, 255));
            end
        end
        if (pat != 0) begin
            frame_in[0][0] = 10;
            frame_in[0][2] = (pat == 2) ? 21 : 20;
            frame_in[0][4] = 30;
            frame_in[0][6] = 40;
        end
    endtask

    task automatic computeModel();
        for (int r = 0; r < H; r += 2) begin
            for (int c = 0; c < W; c++) begin
                if (c % 2 == 0) begin
                    frame_out[r][c] = frame_in[r][c];
                end else if (c == W - 1) begin
                    frame_out[r][c] = frame_in[r][W-2];
                end else begin
                    frame_out[r][c] = (frame_in[r][c-1] + frame_in[r][c+1] + RND) / 2;
                end
            end
            for (int c = 0; c < W; c++) begin
                frame_out[r+1][c] = frame_out[r][c];
            end
        end
    endtask

    task automatic expectAt(input int due, input int val, input int fd);
        exp_t e;
        e.due = due;
        e.val = val;
        e.fd  = fd;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gapMode 0: continuous, 1: 3-cycle gap every 2 beats, 2: random gaps. resetAt >= 0 aborts the frame with a reset.
    task automatic applyStimulus(input int pat, input int gapMode, input int resetAt);
        int r;
        int c;
        buildFrame(pat);
        computeModel();
        for (int b = 0; b < NPIX; b++) begin
            r = b / W;
            c = b % W;
            if (b == resetAt) begin
                valid_in = 1'b0;
                rst      = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (gapMode == 1 && b > 0 && b % 2 == 0) begin
                idle(3);
            end else if (gapMode == 2 && $urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 3)));
            end
            valid_in = 1'b1;
            din      = 8'(frame_in[r][c]);
            @(posedge clk);
            #1;
            if (b >= 2) begin
                expectAt(edge_cnt, frame_out[(b-2)/W][(b-2)%W], 0);
            end
            if (b == NPIX - 1) begin
                expectAt(edge_cnt + 1, frame_out[H-1][W-2], 0);
                expectAt(edge_cnt + 2, frame_out[H-1][W-1], 1);
                fd_expect++;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checkOutput("rst_valid_out", int'(valid_out), 0);
            checkOutput("rst_dout", int'(dout), 0);
            checkOutput("rst_frame_done", int'(frame_done), 0);
        end else if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            e = exp_q.pop_front();
            checkOutput("valid_out", int'(valid_out), 1);
            checkOutput("dout", int'(dout), e.val);
            checkOutput("frame_done", int'(frame_done), e.fd);
        end else begin
            checkOutput("valid_out_idle", int'(valid_out), 0);
            checkOutput("frame_done_idle", int'(frame_done), 0);
        end
        if (!rst && frame_done) fd_seen++;
    end

    initial begin
        int expRow[8];
        expRow = '{10, 15, 20, 25, 30, 35, 40, 40};

        buildFrame(1);
        computeModel();
        for (int c = 0; c < W; c++) begin
            checkOutput("pin_model_row0", frame_out[0][c], expRow[c]);
            checkOutput("pin_model_row1", frame_out[1][c], expRow[c]);
        end
        buildFrame(2);
        computeModel();
        checkOutput("pin_model_round_col1", frame_out[0][1], RND_COL1);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        applyStimulus(1, 0, -1);
        idle(4);
        applyStimulus(2, 0, -1);
        idle(4);
        applyStimulus(1, 1, -1);
        idle(4);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, -1);
        idle(4);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 2, -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        idle(4);

        applyStimulus(0, 0, 2 * W + 3);
        applyStimulus(1, 0, -1);
        idle(4);

        for (int i = 0; i < 4; i++) applyStimulus(0, 2, -1);
        idle(6);

        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("frame_done_count", fd_seen, fd_expect);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/upsample_interp.md
# upsample_interp

Fills the zero-stuffed stream from the 2x upsampler into a full-resolution image for the next SIFT octave. Even rows: each stuffed zero column becomes the average of its horizontal real neighbours. Odd rows (all-zero rows) become a copy of the filled row above, read from a line buffer. Sits directly downstream of the upsampler and consumes its valid/data stream beat-for-beat.

## Interface
- WIDTH, 1600: output pixels per row; must be even and at least 4.
- HEIGHT, 1200: output rows per frame; must be even.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  input beat qualifier; one pixel per cycle with valid_in high; gaps allowed.
- din  in  8  input pixel.
  - Even row, even column: real pixel.
  - Odd column or odd row: stuffed zero; value ignored.
- valid_out  out  1  output beat qualifier; registered.
- dout  out  8  filled pixel; registered.
- frame_done  out  1  one-cycle pulse coincident with the last output beat of a frame.

## Operation
- Counters, input side:
  - in_col, 11 bits: 0..WIDTH-1; wraps to 0 and increments in_row.
  - in_row, 11 bits: 0..HEIGHT-1; wraps to 0 at frame end.
  - Both advance only on valid_in.
- Counters, output side: out_col and out_row, same widths and wrap rules, advance on each output beat.
- Delay pipe: output pixel n is emitted after input beat n+2 arrives.
  - occ (0..2) holds pending beats.
  - valid_in with occ<2: push, no output.
  - valid_in with occ==2: push and emit the oldest pending beat.
- State machine:
  - FILL: occ<2. On a valid beat, occ increments; at occ==2, go to RUN.
  - RUN: emits one output per valid beat. After the last input beat of a frame (in_row=HEIGHT-1, in_col=WIDTH-1) is accepted, go to DRAIN.
  - DRAIN: on each cycle with valid_in low, emit one pending beat with no push.
    - After 2 emits, set occ=0 and go to FILL.
    - valid_in high in DRAIN: the beat is the next frame's beat 0/1; push it and emit one pending beat, identical to RUN behaviour.
    - The old frame still completes in order; return to RUN with no bubble.
- Output value:
  - Even out_row, even out_col c: real pixel p[c/2].
  - Even out_row, odd c < WIDTH-1: avg(p[(c-1)/2], p[(c+1)/2]).
  - Even out_row, c = WIDTH-1: p[WIDTH/2-1] (edge replicate).
  - Odd out_row: linebuf[out_col].
- Averaging: 9-bit sum, shifted right 1; rounding selected by macro (see Configuration).
- Line buffer: WIDTH x 8 single-port RAM.
  - Written at out_col with each even-row output value.
  - Read at out_col for odd-row output.
  - At most one access per cycle; a write and a read of the same address never overlap.
- Reset (any time, including mid-row or in DRAIN):
  - Clears counters and occ; state goes to FILL.
  - valid_out=0, dout=0, frame_done=0.
  - Line buffer contents are not cleared; they are always rewritten before being read.
  - The next valid_in beat is treated as row 0, column 0.

## Timing
- Output register: an emit decided in cycle t appears as valid_out=1 with dout in cycle t+1.
- Steady-state latency: 2 input beats plus 1 cycle.
- With continuous valid_in, output is continuous once 2 beats are buffered.
- frame_done is high in the same cycle as the valid_out of out_row=HEIGHT-1, out_col=WIDTH-1.
- No backpressure: the downstream consumer must accept every valid_out beat.

## Configuration
- INTERP_ROUND_EN defined: avg = (a+b+1)>>1, round half up.
- INTERP_ROUND_EN undefined: avg = (a+b)>>1, truncate.
- No other behaviour changes.

## Test plan
- WIDTH=8, HEIGHT=4, continuous valid. Row 0 input 10,0,20,0,30,0,40,0, row 1 all zero:
  - Output row 0 = 10,15,20,25,30,35,40,40.
  - Output row 1 = same.
  - First valid_out appears 1 cycle after input beat 2.
- Rounding, row 0 input 10,0,21,0,...:
  - out col1 = 16 with INTERP_ROUND_EN.
  - out col1 = 15 without.
- Gappy valid: insert 3-cycle gaps every 2 beats in the first scenario -> identical dout sequence, with valid_out only after accepted beats.
- Frame end with idle input -> last 2 outputs (40,40 of row 3) on the 2 cycles after the last beat (each +1 register); frame_done is high on the final one.
- Back-to-back frames with no idle cycle -> no bubble; frame 1 tail precedes frame 2 pixel 0; frame_done pulses once per frame.
- Assert rst for 1 cycle mid-row 2 -> outputs are 0 that cycle; the following frame restarts at row 0 col 0 with correct values and no stale pipe data.
